hazard_ctrl: RTL and testbench

- Pipeline sequencer for the 5-stage core; fills the hazard-detection slot beside the forwarding unit.
- Generates per-stage enable and flush (bubble) controls for PC and the q1q2, q2q3, q3q4 and q4q5 registers.
- Resolves three hazard classes: load-use (q3 load feeding q2 consumer), taken branch resolved in q4, and data-memory wait states via a valid/ready handshake.
- Adds a wait-state timeout with sticky error/halt, plus saturating performance counters.

---
 rtl/hazard_ctrl.sv | 147 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard sequencer for the 5-stage core: stage enables/bubbles for load-use,
// taken branches and data-memory wait states, with a timeout halt and perf counters.
module hazard_ctrl #(
    parameter int WAIT_TIMEOUT = 16,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ld_q3_i,
    input  logic [4:0]           rd_q3_i,
    input  logic [4:0]           rs1_q2_i,
    input  logic [4:0]           rs2_q2_i,
    input  logic                 use_rs1_q2_i,
    input  logic                 use_rs2_q2_i,
    input  logic                 branch_taken_q4_i,
    input  logic                 dmem_req_i,
    input  logic                 dmem_ready_i,
    output logic                 pc_en_o,
    output logic                 q1q2_en_o,
    output logic                 q2q3_en_o,
    output logic                 q3q4_en_o,
    output logic                 q4q5_en_o,
    output logic                 q1q2_flush_o,
    output logic                 q2q3_flush_o,
    output logic                 q3q4_flush_o,
    output logic                 q4q5_flush_o,
    output logic                 dmem_cancel_o,
    output logic                 halted_o,
    output logic                 bus_err_o,
    output logic [CNT_WIDTH-1:0] stall_cycles_o,
    output logic [CNT_WIDTH-1:0] flush_cnt_o
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

    localparam logic [7:0]           TO_LAST = 8'(WAIT_TIMEOUT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               r_state;
    logic [7:0]           r_wait_cnt;
    logic [CNT_WIDTH-1:0] r_stall_cnt;
    logic [CNT_WIDTH-1:0] r_flush_cnt;
    logic                 r_bus_err;
    logic                 r_halted;

    logic w_loaduse, w_memstall, w_run_eval;
    logic w_br_evt, w_enter_wait, w_timeout;

    assign w_loaduse = ld_q3_i && (rd_q3_i != 5'd0) &&
                       ((use_rs1_q2_i && rs1_q2_i == rd_q3_i) ||
                        (use_rs2_q2_i && rs2_q2_i == rd_q3_i));
    assign w_memstall = dmem_req_i && !dmem_ready_i;
    // A MEM_WAIT cycle whose access completes (or whose request vanished) behaves like RUN
    assign w_run_eval = (r_state == RUN) || (r_state == MEM_WAIT && !w_memstall);

    always_comb begin
        pc_en_o       = 1'b1;
        q1q2_en_o     = 1'b1;
        q2q3_en_o     = 1'b1;
        q3q4_en_o     = 1'b1;
        q4q5_en_o     = 1'b1;
        q1q2_flush_o  = 1'b0;
        q2q3_flush_o  = 1'b0;
        q3q4_flush_o  = 1'b0;
        q4q5_flush_o  = 1'b0;
        dmem_cancel_o = 1'b0;
        w_br_evt      = 1'b0;
        w_enter_wait  = 1'b0;
        w_timeout     = 1'b0;
        if (rst_n) begin
            if (w_run_eval) begin
                if (branch_taken_q4_i) begin
                    q1q2_flush_o  = 1'b1;
                    q2q3_flush_o  = 1'b1;
                    q3q4_flush_o  = 1'b1;
                    dmem_cancel_o = dmem_req_i;
                    w_br_evt      = 1'b1;
                end else if (w_memstall) begin
                    pc_en_o      = 1'b0;
                    q1q2_en_o    = 1'b0;
                    q2q3_en_o    = 1'b0;
                    q3q4_en_o    = 1'b0;
                    q4q5_flush_o = 1'b1;
                    w_enter_wait = 1'b1;
                end else if (w_loaduse) begin
                    pc_en_o      = 1'b0;
                    q1q2_en_o    = 1'b0;
                    q2q3_flush_o = 1'b1;
                end
            end else if (r_state == MEM_WAIT) begin
                pc_en_o      = 1'b0;
                q1q2_en_o    = 1'b0;
                q2q3_en_o    = 1'b0;
                q3q4_en_o    = 1'b0;
                q4q5_flush_o = 1'b1;
                if (r_wait_cnt == TO_LAST) begin
                    dmem_cancel_o = 1'b1;
                    w_timeout     = 1'b1;
                end
            end else begin
                pc_en_o   = 1'b0;
                q1q2_en_o = 1'b0;
                q2q3_en_o = 1'b0;
                q3q4_en_o = 1'b0;
                q4q5_en_o = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_wait_cnt  <= 8'd0;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_bus_err   <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            // The timeout cycle still counts: halted only rises after it
            if (!pc_en_o && !r_halted && r_stall_cnt != CNT_MAX)
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            if (w_br_evt && r_flush_cnt != CNT_MAX)
                r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
            case (r_state)
                RUN: if (w_enter_wait) begin
                    r_state    <= MEM_WAIT;
                    r_wait_cnt <= 8'd1;
                end
                MEM_WAIT: if (!w_memstall) begin
                    r_state    <= RUN;
                    r_wait_cnt <= 8'd0;
                end else if (w_timeout) begin
                    r_state   <= ERROR;
                    r_bus_err <= 1'b1;
                    r_halted  <= 1'b1;
                end else begin
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
                default: r_state <= ERROR;
            endcase
        end
    end

    assign halted_o       = r_halted;
    assign bus_err_o      = r_bus_err;
    assign stall_cycles_o = r_stall_cnt;
    assign flush_cnt_o    = r_flush_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: per-cycle comparison against a rule-level model,
// plus literal counter/flag expectations for each directed scenario.
module tb_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic ld, u1, u2, br, req, rdy;
    logic [4:0] rd, rs1, rs2;
    logic pc_en, e1, e2, e3, e4, f1, f2, f3, f4, cancel, halted, bus_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_ctrl #(.WAIT_TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_q3_i(ld), .rd_q3_i(rd), .rs1_q2_i(rs1), .rs2_q2_i(rs2),
        .use_rs1_q2_i(u1), .use_rs2_q2_i(u2), .branch_taken_q4_i(br),
        .dmem_req_i(req), .dmem_ready_i(rdy),
        .pc_en_o(pc_en), .q1q2_en_o(e1), .q2q3_en_o(e2), .q3q4_en_o(e3), .q4q5_en_o(e4),
        .q1q2_flush_o(f1), .q2q3_flush_o(f2), .q3q4_flush_o(f3), .q4q5_flush_o(f4),
        .dmem_cancel_o(cancel), .halted_o(halted), .bus_err_o(bus_err),
        .stall_cycles_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    always #5 clk = ~clk;

    // Model state: waiting on memory, cycles waited so far, halted, counters
    bit m_wait = 0, m_err = 0;
    int m_wcnt = 0, m_stall = 0, m_flush = 0;
    logic [9:0] e, got;  // {pc,e1,e2,e3,e4,f1,f2,f3,f4,cancel}
    bit lu, ms, waiting_stall;

    always @(negedge clk) begin
        lu = ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        ms = req && !rdy;
        waiting_stall = m_wait && ms;
        e = 10'b11111_00000;
        if (!rst_n) begin
            m_wait = 0; m_err = 0; m_wcnt = 0; m_stall = 0; m_flush = 0;
        end else if (m_err) e = 10'b0;
        else if (waiting_stall) begin
            e = 10'b00001_00010;
            if (m_wcnt == TO - 1) e[0] = 1'b1;
        end else if (br) begin
            e[4:2] = 3'b111;
            e[0] = req;
        end else if (ms) e = 10'b00001_00010;
        else if (lu) begin
            e[9:8] = 2'b00;
            e[3] = 1'b1;
        end
        got = {pc_en, e1, e2, e3, e4, f1, f2, f3, f4, cancel};
        n_cmp++;
        if (got !== e || stall_cnt !== CW'(m_stall) || flush_cnt !== CW'(m_flush) ||
            halted !== m_err || bus_err !== m_err) begin
            n_bad++;
            $display("FAIL cycle t=%0t ctl got %b want %b stall got %0d want %0d flush got %0d want %0d err got %b%b want %b",
                     $time, got, e, stall_cnt, m_stall, flush_cnt, m_flush, halted, bus_err, m_err);
        end
        if (rst_n && !m_err) begin
            if (!e[9] && m_stall < CMAX) m_stall++;
            if (!waiting_stall && br && m_flush < CMAX) m_flush++;
            if (m_wait) begin
                if (!ms) begin m_wait = 0; m_wcnt = 0; end
                else if (m_wcnt == TO - 1) begin m_err = 1; m_wait = 0; end
                else m_wcnt++;
            end else if (!br && ms) begin
                m_wait = 1; m_wcnt = 1;
            end
        end
    end

    task automatic step(input logic a_ld, input logic [4:0] a_rd, input logic [4:0] a_rs1,
                        input logic [4:0] a_rs2, input logic a_u1, input logic a_u2,
                        input logic a_br, input logic a_req, input logic a_rdy);
        ld = a_ld; rd = a_rd; rs1 = a_rs1; rs2 = a_rs2; u1 = a_u1; u2 = a_u2;
        br = a_br; req = a_req; rdy = a_rdy;
        @(posedge clk); #1;
    endtask

    task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0, 0); endtask

    task automatic do_reset();
        rst_n = 1'b0; idle(); rst_n = 1'b1; idle();
    endtask

    task automatic lit(input string name, input int g, input int w);
        n_cmp++;
        if (g != w) begin
            n_bad++;
            $display("FAIL %s got %0d want %0d", name, g, w);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ld = 0; rd = 0; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; br = 0; req = 0; rdy = 0;
        idle(); idle();
        lit("reset_stall", int'(stall_cnt), 0);
        rst_n = 1'b1; idle();

        // lw x5 ; add using x5 as rs2: a single bubble
        step(1, 5, 1, 5, 1, 1, 0, 0, 0);
        lit("lu_stall", int'(stall_cnt), 1);
        step(0, 5, 1, 5, 1, 1, 0, 0, 0);
        lit("lu_no_second", int'(stall_cnt), 1);

        // x0 destination never stalls
        do_reset();
        step(1, 0, 0, 0, 1, 1, 0, 0, 0);
        lit("x0_stall", int'(stall_cnt), 0);

        // three not-ready cycles then ready
        do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        lit("mem_stall", int'(stall_cnt), 3);
        idle();
        lit("mem_stall_after", int'(stall_cnt), 3);

        // branch beats load-use and memstall together
        do_reset();
        step(1, 7, 7, 0, 1, 0, 1, 1, 0);
        lit("br_flush_cnt", int'(flush_cnt), 1);
        lit("br_stall", int'(stall_cnt), 0);
        idle();
        lit("br_no_wait", int'(stall_cnt), 0);

        // timeout: error on the 4th not-ready cycle
        do_reset();
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        lit("to_not_yet", int'(bus_err), 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        lit("to_bus_err", int'(bus_err), 1);
        lit("to_halted", int'(halted), 1);
        lit("to_stall", int'(stall_cnt), 4);
        repeat (2) step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        lit("to_stall_hold", int'(stall_cnt), 4);
        do_reset();
        lit("to_cleared", int'(bus_err) + int'(halted), 0);

        // reset in the middle of a wait
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 1, 0);
        rst_n = 1'b1;
        idle();
        lit("midwait_pc_en", int'(pc_en), 1);

        // 20 load-use stalls saturate the 4-bit counter
        do_reset();
        repeat (20) step(1, 3, 3, 0, 1, 0, 0, 0, 0);
        lit("sat_stall", int'(stall_cnt), 15);

        // mixed traffic, checked cycle by cycle
        do_reset();
        for (int i = 0; i < 80; i++) begin
            if (i % 20 == 19) do_reset();
            step($urandom_range(0, 1), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)), $urandom_range(0, 1), $urandom_range(0, 1),
                 !m_wait && $urandom_range(0, 5) == 0, $urandom_range(0, 1), $urandom_range(0, 1));
        end
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
